// File: rtl/yolo_pkg.sv
// Shared definitions for the YOLOv3-Tiny front-end blocks: pixel word width
// and a constant-evaluable log2 helper used to size address fields.
package yolo_pkg;

    localparam int PIXEL_WIDTH = 32;

    // Ceiling log2, usable in parameter defaults; returns 0 for value <= 1
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for stream_fifo: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_ram
    import yolo_pkg::*;
#(
    parameter int DATA_WIDTH = PIXEL_WIDTH,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: the word becomes visible on the read port after this edge
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port is combinational so the head word is presented fall-through
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO between the bitmap/pixel word source and the
// first conv stage. full asserts FULL_SLACK entries early because the source
// reacts to full one cycle late; writes that still find no room are dropped
// and latch the sticky overflow flag.
module stream_fifo
    import yolo_pkg::*;
#(
    parameter int DATA_WIDTH = PIXEL_WIDTH,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = clog2(DEPTH),
    parameter int FULL_SLACK = 1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0] COUNT_MAX   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] FULL_THRESH = (ADDR_WIDTH + 1)'(DEPTH - FULL_SLACK);
    localparam logic [ADDR_WIDTH:0] COUNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_WIDTH:0]   count_reg,  count_next;
    logic                  overflow_reg, overflow_next;

    logic pop;
    logic push;
    logic drop;

    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign pop  = valid_out & ready_in;
    assign push = valid_in & ((count_reg < COUNT_MAX) | pop);
    assign drop = valid_in & ~push;

    // Next-state for pointers, occupancy and the sticky overflow flag;
    // pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg | drop;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + COUNT_ONE;
            2'b01:   count_next = count_reg - COUNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // State registers; reset empties the FIFO immediately and rewinds to entry 0
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .Clk     (Clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (data_in),
        .rd_addr (rd_ptr_reg),
        .rd_data (data_out)
    );

    // Flags decode from the count register only, so no input reaches them
    // combinationally and a push into an empty FIFO is not bypassed
    assign full      = (count_reg >= FULL_THRESH);
    assign empty     = (count_reg == '0);
    assign valid_out = ~empty;
    assign count     = count_reg;
    assign overflow  = overflow_reg;

endmodule
